// File: rtl/br_ctrl_pkg.sv
// Shared types and constants for the branch redirect controller slice.
// Imported by branch_redirect_ctrl, its interface, and the optional br_perf_counters.
package br_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } br_state_e;

  localparam int FLUSH_CNT_W = 3;

  // Encoding of addi x0,x0,0, inserted into IF/ID when it is squashed
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic calc_take(input logic ex_valid,
                                     input logic ex_is_br,
                                     input logic br_true,
                                     input logic ex_is_jump);
    return ex_valid & ((ex_is_br & br_true) | ex_is_jump);
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// EX-stage to fetch/IF-ID handshake bundle for branch_redirect_ctrl.
// Perf counter signals exist only when BR_PERF_CNT_EN is defined.
interface branch_redirect_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);

  logic            ex_valid;
  logic            ex_is_br;
  logic            ex_is_jump;
  logic            br_true;
  logic [XLEN-1:0] br_target;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_if;
  logic            misalign;
  logic            busy;
`ifdef BR_PERF_CNT_EN
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;
  logic [CNT_W-1:0] stall_redirect_count;
`endif

  // master is the EX stage / environment, slave is the redirect controller
  modport master (
    output ex_valid, ex_is_br, ex_is_jump, br_true, br_target, stall,
    input  redirect_valid, redirect_pc, flush_if, misalign,
`ifdef BR_PERF_CNT_EN
    input  br_count, taken_count, stall_redirect_count,
`endif
    input  busy
  );

  modport slave (
    input  ex_valid, ex_is_br, ex_is_jump, br_true, br_target, stall,
    output redirect_valid, redirect_pc, flush_if, misalign,
`ifdef BR_PERF_CNT_EN
    output br_count, taken_count, stall_redirect_count,
`endif
    output busy
  );

endinterface

// File: rtl/br_perf_counters.sv
// Branch statistics counters, instantiated by branch_redirect_ctrl only under BR_PERF_CNT_EN.
// All counters wrap naturally at 2^CNT_W.
module br_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_idle,
  input  logic             is_branch,
  input  logic             take,
  input  logic             stall,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] stall_redirect_count
);

  // Only IDLE samples count; EX traffic during PEND/FLUSH is wrong-path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count             <= '0;
      taken_count          <= '0;
      stall_redirect_count <= '0;
    end else if (in_idle) begin
      if (is_branch)    br_count             <= br_count + 1'b1;
      if (take)         taken_count          <= taken_count + 1'b1;
      if (take & stall) stall_redirect_count <= stall_redirect_count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch redirect controller: turns a resolved branch/jump into a one-cycle
// PC redirect pulse plus an IF/ID flush. Optional perf counters under BR_PERF_CNT_EN.
module branch_redirect_ctrl
  import br_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input logic                   clk,
  input logic                   rst,
  branch_redirect_ctrl_if.slave bus
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES);

  br_state_e              state;
  logic [XLEN-1:0]        tgt_q;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic                   redirect_valid_q;
  logic [XLEN-1:0]        redirect_pc_q;
  logic                   flush_if_q;
  logic                   misalign_q;
  logic                   take;
  logic [XLEN-1:0]        issue_tgt;

  assign take      = calc_take(bus.ex_valid, bus.ex_is_br, bus.br_true, bus.ex_is_jump);
  assign issue_tgt = (state == PEND) ? tgt_q : bus.br_target;

  // Single FSM: the redirect pulse and misalign are cleared every cycle unless a
  // redirect is being issued, so each redirect yields exactly one pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      tgt_q            <= '0;
      flush_cnt        <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_if_q       <= 1'b0;
      misalign_q       <= 1'b0;
    end else begin
      redirect_valid_q <= 1'b0;
      misalign_q       <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            tgt_q <= bus.br_target;
            if (bus.stall) begin
              state <= PEND;
            end else begin
              state            <= FLUSH;
              redirect_valid_q <= 1'b1;
              redirect_pc_q    <= {issue_tgt[XLEN-1:1], 1'b0};
              misalign_q       <= issue_tgt[1];
              flush_if_q       <= 1'b1;
              flush_cnt        <= FLUSH_INIT;
            end
          end
        end
        PEND: begin
          if (!bus.stall) begin
            state            <= FLUSH;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= {issue_tgt[XLEN-1:1], 1'b0};
            misalign_q       <= issue_tgt[1];
            flush_if_q       <= 1'b1;
            flush_cnt        <= FLUSH_INIT;
          end
        end
        FLUSH: begin
          // The flush cycle that just completed consumes one count; a stall freezes it
          if (!bus.stall) begin
            if (flush_cnt <= FLUSH_CNT_W'(1)) begin
              flush_cnt  <= '0;
              flush_if_q <= 1'b0;
              state      <= IDLE;
            end else begin
              flush_cnt <= flush_cnt - 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          flush_if_q <= 1'b0;
          flush_cnt  <= '0;
        end
      endcase
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush_if       = flush_if_q;
  assign bus.misalign       = misalign_q;
  assign bus.busy           = (state != IDLE);

`ifdef BR_PERF_CNT_EN
  br_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk                 (clk),
    .rst                 (rst),
    .in_idle             (state == IDLE),
    .is_branch           (bus.ex_valid & bus.ex_is_br),
    .take                (take),
    .stall               (bus.stall),
    .br_count            (bus.br_count),
    .taken_count         (bus.taken_count),
    .stall_redirect_count(bus.stall_redirect_count)
  );
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: dut_a uses FLUSH_CYCLES=1, dut_b FLUSH_CYCLES=2,
// both driven with identical stimulus. Counter checks compile in with BR_PERF_CNT_EN.
module tb_branch_redirect_ctrl;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  branch_redirect_ctrl_if #(.XLEN(32), .CNT_W(32)) a_if ();
  branch_redirect_ctrl_if #(.XLEN(32), .CNT_W(32)) b_if ();

  branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(1), .CNT_W(32)) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(a_if.slave)
  );

  branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(32)) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic valid, input logic is_br, input logic is_jump,
                                input logic cond, input logic [31:0] target, input logic stl);
    a_if.ex_valid   = valid;  b_if.ex_valid   = valid;
    a_if.ex_is_br   = is_br;  b_if.ex_is_br   = is_br;
    a_if.ex_is_jump = is_jump; b_if.ex_is_jump = is_jump;
    a_if.br_true    = cond;   b_if.br_true    = cond;
    a_if.br_target  = target; b_if.br_target  = target;
    a_if.stall      = stl;    b_if.stall      = stl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    apply_stimulus(0, 0, 0, 0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_rv",    32'(a_if.redirect_valid), 32'd0);
    check_output("rst_pc",    a_if.redirect_pc,         32'd0);
    check_output("rst_flush", 32'(a_if.flush_if),       32'd0);
    check_output("rst_mis",   32'(a_if.misalign),       32'd0);
    check_output("rst_busy",  32'(a_if.busy),           32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] taken BEQ to 0x100");
    apply_stimulus(1, 1, 0, 1, 32'h0000_0100, 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 32'h0, 0);
    check_output("beq_rv",      32'(a_if.redirect_valid), 32'd1);
    check_output("beq_pc",      a_if.redirect_pc,         32'h100);
    check_output("beq_flush",   32'(a_if.flush_if),       32'd1);
    check_output("beq_mis",     32'(a_if.misalign),       32'd0);
    check_output("beq_busy",    32'(a_if.busy),           32'd1);
    check_output("beq_b_rv",    32'(b_if.redirect_valid), 32'd1);
    tick();
    check_output("beq_rv_off",  32'(a_if.redirect_valid), 32'd0);
    check_output("beq_fl_off",  32'(a_if.flush_if),       32'd0);
    check_output("beq_busy_off", 32'(a_if.busy),          32'd0);
    check_output("beq_b_fl2",   32'(b_if.flush_if),       32'd1);
    check_output("beq_b_rv2",   32'(b_if.redirect_valid), 32'd0);
    tick();
    check_output("beq_b_fl3",   32'(b_if.flush_if),       32'd0);
    check_output("beq_b_busy3", 32'(b_if.busy),           32'd0);

    $display("[TB] branch not taken");
    apply_stimulus(1, 1, 0, 0, 32'h0000_0180, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_output("nt_rv",    32'(a_if.redirect_valid), 32'd0);
      check_output("nt_flush", 32'(a_if.flush_if),       32'd0);
      check_output("nt_busy",  32'(a_if.busy),           32'd0);
    end
    check_output("nt_pc_hold", a_if.redirect_pc, 32'h100);
    apply_stimulus(0, 1, 0, 1, 32'h0000_01C0, 0);
    tick();
    check_output("novalid_busy", 32'(a_if.busy), 32'd0);

    $display("[TB] stalled resolve to 0x200");
    apply_stimulus(1, 1, 0, 1, 32'h0000_0200, 1);
    tick();
    apply_stimulus(0, 0, 0, 0, 32'h0, 1);
    check_output("stl_busy0", 32'(a_if.busy),           32'd1);
    check_output("stl_rv0",   32'(a_if.redirect_valid), 32'd0);
    for (int i = 1; i < 3; i++) begin
      tick();
      check_output("stl_busy", 32'(a_if.busy),           32'd1);
      check_output("stl_rv",   32'(a_if.redirect_valid), 32'd0);
      check_output("stl_fl",   32'(a_if.flush_if),       32'd0);
    end
    apply_stimulus(0, 0, 0, 0, 32'h0, 0);
    tick();
    check_output("stl_rv_go", 32'(a_if.redirect_valid), 32'd1);
    check_output("stl_pc",    a_if.redirect_pc,         32'h200);
    check_output("stl_fl_go", 32'(a_if.flush_if),       32'd1);
    tick();
    check_output("stl_done", 32'(a_if.busy), 32'd0);
    tick();

    $display("[TB] JALR odd target 0x107, take during FLUSH ignored");
    apply_stimulus(1, 0, 1, 0, 32'h0000_0107, 0);
    tick();
    apply_stimulus(1, 1, 0, 1, 32'h0000_0400, 0);
    check_output("jalr_b_rv",  32'(b_if.redirect_valid), 32'd1);
    check_output("jalr_b_pc",  b_if.redirect_pc,         32'h106);
    check_output("jalr_b_mis", 32'(b_if.misalign),       32'd1);
    check_output("jalr_b_fl1", 32'(b_if.flush_if),       32'd1);
    check_output("jalr_a_mis", 32'(a_if.misalign),       32'd1);
    tick();
    apply_stimulus(0, 0, 0, 0, 32'h0, 0);
    check_output("jalr_b_rv2",  32'(b_if.redirect_valid), 32'd0);
    check_output("jalr_b_mis2", 32'(b_if.misalign),       32'd0);
    check_output("jalr_b_fl2",  32'(b_if.flush_if),       32'd1);
    check_output("jalr_b_busy", 32'(b_if.busy),           32'd1);
    check_output("jalr_a_rv2",  32'(a_if.redirect_valid), 32'd0);
    tick();
    check_output("jalr_b_fl3", 32'(b_if.flush_if),       32'd0);
    check_output("jalr_b_rv3", 32'(b_if.redirect_valid), 32'd0);
    check_output("jalr_a_rv3", 32'(a_if.redirect_valid), 32'd0);
    check_output("jalr_b_pc3", b_if.redirect_pc,         32'h106);

    $display("[TB] stall during FLUSH holds the flush counter");
    apply_stimulus(1, 0, 1, 0, 32'h0000_0020, 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 32'h0, 1);
    check_output("fst_b_rv", 32'(b_if.redirect_valid), 32'd1);
    tick();
    check_output("fst_b_fl1", 32'(b_if.flush_if), 32'd1);
    check_output("fst_a_fl1", 32'(a_if.flush_if), 32'd1);
    tick();
    check_output("fst_b_fl2", 32'(b_if.flush_if), 32'd1);
    apply_stimulus(0, 0, 0, 0, 32'h0, 0);
    tick();
    check_output("fst_b_fl3", 32'(b_if.flush_if), 32'd1);
    check_output("fst_a_fl3", 32'(a_if.flush_if), 32'd0);
    tick();
    check_output("fst_b_fl4",  32'(b_if.flush_if), 32'd0);
    check_output("fst_b_busy", 32'(b_if.busy),     32'd0);

    $display("[TB] reset during PEND");
    apply_stimulus(1, 1, 0, 1, 32'h0000_02C0, 1);
    tick();
    check_output("rp_busy_pend", 32'(a_if.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_output("rp_busy", 32'(a_if.busy),           32'd0);
    check_output("rp_rv",   32'(a_if.redirect_valid), 32'd0);
    check_output("rp_pc",   a_if.redirect_pc,         32'd0);
    check_output("rp_fl",   32'(a_if.flush_if),       32'd0);
    apply_stimulus(0, 0, 0, 0, 32'h0, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_output("rp_no_rv",   32'(a_if.redirect_valid), 32'd0);
      check_output("rp_no_busy", 32'(a_if.busy),           32'd0);
    end
    apply_stimulus(1, 1, 0, 1, 32'h0000_0300, 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 32'h0, 0);
    check_output("rp_new_rv", 32'(a_if.redirect_valid), 32'd1);
    check_output("rp_new_pc", a_if.redirect_pc,         32'h300);
    repeat (2) tick();

`ifdef BR_PERF_CNT_EN
    $display("[TB] perf counters");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_output("pc_rst_br", a_if.br_count, 32'd0);
    apply_stimulus(1, 1, 0, 0, 32'h0000_0500, 0);
    tick();
    apply_stimulus(1, 1, 0, 1, 32'h0000_0504, 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 32'h0, 0);
    repeat (3) tick();
    apply_stimulus(1, 1, 0, 0, 32'h0000_0508, 0);
    tick();
    apply_stimulus(1, 1, 0, 1, 32'h0000_050C, 1);
    tick();
    apply_stimulus(0, 0, 0, 0, 32'h0, 1);
    tick();
    apply_stimulus(0, 0, 0, 0, 32'h0, 0);
    repeat (4) tick();
    apply_stimulus(1, 0, 1, 0, 32'h0000_0600, 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 32'h0, 0);
    repeat (3) tick();
    check_output("pc_br",    a_if.br_count,             32'd4);
    check_output("pc_taken", a_if.taken_count,          32'd3);
    check_output("pc_stall", a_if.stall_redirect_count, 32'd1);
    check_output("pc_b_br",  b_if.br_count,             32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
